// File: rtl/rr_mux_arb_pkg.sv
// rtl/rr_mux_arb_pkg.sv - shared constants and index helper for the round-robin mux
package rr_mux_pkg;

    localparam logic MODE_FIXED       = 1'b0;
    localparam logic MODE_ROUND_ROBIN = 1'b1;

    // Rotate-left index: position of slot `offset` when the ring starts at `base`.
    function automatic logic [31:0] wrap_idx(
        input logic [31:0] base,
        input logic [31:0] offset,
        input logic [31:0] modulus
    );
        return (base + offset) % modulus;
    endfunction

endpackage

// File: rtl/rr_mux_arb_if.sv
// rtl/rr_mux_arb_if.sv - producer-side and consumer-side handshake bundle of the mux
interface rr_mux_arb_if #(
    parameter int N = 2,
    parameter int W = 8
) ();
    localparam int X = 1 << N;

    logic [X-1:0]   in_valid;
    logic [X*W-1:0] in_data;
    logic [X-1:0]   in_ready;
    logic           mode;
    logic [N-1:0]   sel;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [N-1:0]   out_ch;
    logic           out_ready;

    modport master (
        output in_valid, in_data, mode, sel, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, mode, sel, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/rr_mux_arb_arbiter.sv
// rtl/rr_mux_arb_arbiter.sv - combinational rotate / priority-find / un-rotate grant
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int X = 4,
    parameter int N = $clog2(X)
) (
    input  logic [X-1:0] req,
    input  logic [N-1:0] ptr,
    output logic         gnt_valid,
    output logic [N-1:0] gnt_idx
);

    logic [X-1:0] w_rot;
    logic [N-1:0] w_first;
    logic         w_found;

    // Slot 0 of the rotated vector is the channel at ptr, so the lowest set slot is the fair winner.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < X; i++) begin
            w_rot[i] = req[N'(wrap_idx(32'(ptr), 32'(i), 32'(X)))];
        end

        w_found = 1'b0;
        w_first = '0;
        for (int i = X - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_found = 1'b1;
                w_first = N'(i);
            end
        end
    end

    assign gnt_valid = w_found;
    assign gnt_idx   = N'(wrap_idx(32'(ptr), 32'(w_first), 32'(X)));

endmodule

// File: rtl/rr_mux_arb.sv
// rtl/rr_mux_arb.sv - registered 2**N:1 mux with fixed or round-robin channel arbitration
module rr_mux_arb
    import rr_mux_pkg::*;
#(
    parameter int N = 2,
    parameter int W = 8,
    parameter int X = 1 << N
) (
    input logic          clk,
    input logic          rst_n,
    rr_mux_arb_if.slave  bus
);

    logic [N-1:0] r_ptr;
    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    logic [N-1:0] r_out_ch;

    logic         w_rr_valid;
    logic [N-1:0] w_rr_idx;
    logic         w_load;
    logic         w_gnt_valid;
    logic [N-1:0] w_gnt_idx;
    logic         w_xfer;
    logic [X-1:0] w_in_ready;
    logic [W-1:0] w_gnt_data;

    rr_arbiter #(
        .X (X),
        .N (N)
    ) u_arb (
        .req       (bus.in_valid),
        .ptr       (r_ptr),
        .gnt_valid (w_rr_valid),
        .gnt_idx   (w_rr_idx)
    );

    // Reset gates the load enable so no channel sees ready while the output stage is cleared.
    always_comb begin
        w_load = rst_n && (!r_out_valid || bus.out_ready);

        if (bus.mode == MODE_ROUND_ROBIN) begin
            w_gnt_valid = w_rr_valid;
            w_gnt_idx   = w_rr_idx;
        end else begin
            w_gnt_valid = bus.in_valid[bus.sel];
            w_gnt_idx   = bus.sel;
        end

        w_xfer     = w_load && w_gnt_valid;
        w_in_ready = '0;
        if (w_xfer) begin
            w_in_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign w_gnt_data = bus.in_data[32'(w_gnt_idx) * W +: W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_load) begin
            if (w_gnt_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gnt_data;
                r_out_ch    <= w_gnt_idx;
                if (bus.mode == MODE_ROUND_ROBIN) begin
                    r_ptr <= N'(wrap_idx(32'(w_gnt_idx), 32'd1, 32'(X)));
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;

endmodule
